ctrl_sequencer: RTL and testbench
=================================

// Module: ctrl_sequencer
// PURPOSE
//  Registered, handshaked successor to the single-cycle control decoder. Accepts one
//  instruction (opcode, func1) per valid/ready handshake, decodes it to the datapath
//  control bundle and sequences multi-cycle behaviour: holds memory controls until
//  mem_ready or timeout, inserts post-jump bubbles, honours flush, flags illegal opcodes.
// PARAMETERS
//  ALU_SEL_W     4   width of alu_select
//  MEM_TIMEOUT   16  max MEM_WAIT cycles before mem_error (>=1)
//  JUMP_BUBBLES  2   dead cycles after a jump issues (0 = none)
//  COUNT_W       16  width of retired-instruction counter
// PORTS
//  clock         in   1          system clock, all state on rising edge
//  reset         in   1          synchronous, active-high
//  instr_valid   in   1          opcode/func1 valid this cycle
//  instr_ready   out  1          block can accept an instruction (=1 only in IDLE)
//  opcode        in   4          instruction opcode
//  func1         in   1          opcode sub-select
//  mem_ready     in   1          memory completed current access
//  flush         in   1          abort current instruction, return to IDLE
//  ctrl_valid    out  1          control bundle below is live
//  shift_control out  2          00 none, 01 shift left, 11 shift right
//  mem_read/mem_write out 1 each memory strobes
//  imm_type      out  1          immediate operand select
//  alu_select    out  ALU_SEL_W  ALU op code (zero-extended from table)
//  copy_reg      out  1          register copy
//  br_eq,br_neq,br_lt,br_gt,br_lte,br_gte out 1 each  branch conditions
//  jump          out  1          unconditional jump
//  illegal_op    out  1          1-cycle pulse: opcode 4'hF accepted
//  mem_error     out  1          1-cycle pulse: MEM_TIMEOUT reached
//  retired_count out  COUNT_W    instructions completed, wraps to 0
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0 (instr_ready=1 after reset deasserts), counters 0.
//  Decode table (f=func1; unlisted signals 0):
//   0:nop  1:f?mem_write:mem_read  2:as 1 +imm_type  3:alu_select=f?3:2  4:as 3 +imm_type
//   5:shift=f?11:01  6:as 5 +imm_type  7:f?alu=1:nop  8:imm_type, f?alu=1  9:f?br_neq:br_eq
//   A:f?br_lt:br_gt  B:f?br_lte:br_gte  C:jump+imm_type  D:jump  E:copy_reg  F:illegal
//  Accept = instr_valid & instr_ready. Latency 1: bundle and ctrl_valid register on the
//   accepting edge, visible next cycle.
//  IDLE: non-mem op -> bundle+ctrl_valid for exactly 1 cycle, retired_count+1; back-to-back
//   accepts give continuous ctrl_valid. Opcode F: ctrl_valid=0, illegal_op=1, not retired.
//  Mem op (1,2) -> MEM_WAIT: bundle and ctrl_valid held, wait_cnt counts from 0 per cycle.
//  MEM_WAIT: mem_ready=1 -> outputs 0 next cycle, retired_count+1, IDLE. wait_cnt reaching
//   MEM_TIMEOUT-1 without mem_ready -> mem_error pulse, outputs 0, IDLE, not retired.
//   mem_ready and timeout same cycle -> completion wins, no error.
//  Jump (C,D): 1-cycle bundle, retired, then BUBBLE for JUMP_BUBBLES cycles, instr_ready=0,
//   ctrl_valid=0; then IDLE. JUMP_BUBBLES=0 -> stays IDLE.
//  flush (any state): next cycle outputs 0, IDLE, no retire, no mem_error; instruction
//   offered with flush is not accepted. Priority: reset > flush > mem_ready > timeout.
//  mem_ready outside MEM_WAIT ignored. retired_count wraps 2^COUNT_W-1 -> 0.
// TESTING
//  1. reset; opcode 3,f=1 valid 1 cycle -> next cycle ctrl_valid=1, alu_select=3, then 0; count=1.
//  2. opcode 1,f=0; mem_ready at 4th wait cycle -> mem_read held 4 cycles, instr_ready=0, count+1.
//  3. opcode 2,f=1, no mem_ready -> mem_write+imm_type held 16 cycles, mem_error pulse, count same.
//  4. opcode D then opcode 5 held valid -> jump 1 cycle, 2 idle cycles, then shift=01.
//  5. flush during MEM_WAIT with opcode 9 valid -> outputs 0 next cycle, 9 not accepted, no error.
//  6. opcode F -> illegal_op pulse, ctrl_valid 0; COUNT_W=2, 5 nops -> retired_count=1.

Source files
------------

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: handshaked instruction decoder that sequences memory waits, jump bubbles, flush and illegal ops
module ctrl_sequencer #(
  parameter int ALU_SEL_W    = 4,
  parameter int MEM_TIMEOUT  = 16,
  parameter int JUMP_BUBBLES = 2,
  parameter int COUNT_W      = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [3:0]           opcode,
  input  logic                 func1,
  input  logic                 mem_ready,
  input  logic                 flush,
  output logic                 ctrl_valid,
  output logic [1:0]           shift_control,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 imm_type,
  output logic [ALU_SEL_W-1:0] alu_select,
  output logic                 copy_reg,
  output logic                 br_eq,
  output logic                 br_neq,
  output logic                 br_lt,
  output logic                 br_gt,
  output logic                 br_lte,
  output logic                 br_gte,
  output logic                 jump,
  output logic                 illegal_op,
  output logic                 mem_error,
  output logic [COUNT_W-1:0]   retired_count
);
  typedef enum logic [1:0] {IDLE, MEM_WAIT, BUBBLE} state_t;
  typedef struct packed {
    logic [1:0]           shift;
    logic                 mem_read;
    logic                 mem_write;
    logic                 imm_type;
    logic [ALU_SEL_W-1:0] alu;
    logic                 copy_reg;
    logic                 br_eq;
    logic                 br_neq;
    logic                 br_lt;
    logic                 br_gt;
    logic                 br_lte;
    logic                 br_gte;
    logic                 jump;
  } bundle_t;
  localparam int WW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
  localparam int BW = JUMP_BUBBLES > 1 ? $clog2(JUMP_BUBBLES) : 1;
  state_t state, state_n;
  bundle_t dec, bundle, bundle_n;
  logic valid_n, illegal_n, error_n, accept, is_mem, is_jump;
  logic [WW-1:0] wait_cnt, wait_n;
  logic [BW-1:0] bub_cnt, bub_n;
  logic [COUNT_W-1:0] count_n;
  assign instr_ready = state == IDLE;
  assign accept = instr_valid & instr_ready & ~flush;
  assign is_mem = opcode == 4'h1 || opcode == 4'h2;
  assign is_jump = opcode[3:1] == 3'b110;
  always_comb begin
    dec = '0;
    case (opcode)
      4'h1, 4'h2: begin
        dec.mem_write = func1;
        dec.mem_read = ~func1;
        dec.imm_type = opcode == 4'h2;
      end
      4'h3, 4'h4: begin
        dec.alu = func1 ? ALU_SEL_W'(3) : ALU_SEL_W'(2);
        dec.imm_type = opcode == 4'h4;
      end
      4'h5, 4'h6: begin
        dec.shift = func1 ? 2'b11 : 2'b01;
        dec.imm_type = opcode == 4'h6;
      end
      4'h7, 4'h8: begin
        dec.alu = func1 ? ALU_SEL_W'(1) : ALU_SEL_W'(0);
        dec.imm_type = opcode == 4'h8;
      end
      4'h9: begin
        dec.br_neq = func1;
        dec.br_eq = ~func1;
      end
      4'hA: begin
        dec.br_lt = func1;
        dec.br_gt = ~func1;
      end
      4'hB: begin
        dec.br_lte = func1;
        dec.br_gte = ~func1;
      end
      4'hC: begin
        dec.jump = 1'b1;
        dec.imm_type = 1'b1;
      end
      4'hD: dec.jump = 1'b1;
      4'hE: dec.copy_reg = 1'b1;
      default: ;
    endcase
  end
  always_comb begin
    state_n = state;
    bundle_n = '0;
    valid_n = 1'b0;
    illegal_n = 1'b0;
    error_n = 1'b0;
    wait_n = wait_cnt;
    bub_n = bub_cnt;
    count_n = retired_count;
    if (flush)
      state_n = IDLE;
    else
      case (state)
        IDLE:
          if (accept) begin
            if (opcode == 4'hF)
              illegal_n = 1'b1;
            else begin
              bundle_n = dec;
              valid_n = 1'b1;
              if (is_mem) begin
                state_n = MEM_WAIT;
                wait_n = '0;
              end else begin
                count_n = retired_count + COUNT_W'(1);
                if (is_jump && JUMP_BUBBLES > 0) begin
                  state_n = BUBBLE;
                  bub_n = '0;
                end
              end
            end
          end
        MEM_WAIT:
          if (mem_ready) begin
            state_n = IDLE;
            count_n = retired_count + COUNT_W'(1);
          end else if (wait_cnt == WW'(MEM_TIMEOUT - 1)) begin
            state_n = IDLE;
            error_n = 1'b1;
          end else begin
            bundle_n = bundle;
            valid_n = 1'b1;
            wait_n = wait_cnt + WW'(1);
          end
        BUBBLE:
          if (bub_cnt == BW'(JUMP_BUBBLES - 1))
            state_n = IDLE;
          else
            bub_n = bub_cnt + BW'(1);
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      bundle <= '0;
      ctrl_valid <= 1'b0;
      illegal_op <= 1'b0;
      mem_error <= 1'b0;
      wait_cnt <= '0;
      bub_cnt <= '0;
      retired_count <= '0;
    end else begin
      state <= state_n;
      bundle <= bundle_n;
      ctrl_valid <= valid_n;
      illegal_op <= illegal_n;
      mem_error <= error_n;
      wait_cnt <= wait_n;
      bub_cnt <= bub_n;
      retired_count <= count_n;
    end
  end
  assign shift_control = bundle.shift;
  assign mem_read = bundle.mem_read;
  assign mem_write = bundle.mem_write;
  assign imm_type = bundle.imm_type;
  assign alu_select = bundle.alu;
  assign copy_reg = bundle.copy_reg;
  assign br_eq = bundle.br_eq;
  assign br_neq = bundle.br_neq;
  assign br_lt = bundle.br_lt;
  assign br_gt = bundle.br_gt;
  assign br_lte = bundle.br_lte;
  assign br_gte = bundle.br_gte;
  assign jump = bundle.jump;
endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: directed self-checking bench for ctrl_sequencer
module tb_ctrl_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic instr_valid = 1'b0, func1 = 1'b0, mem_ready = 1'b0, flush = 1'b0;
  logic [3:0] opcode = '0;
  logic instr_ready, ctrl_valid, mem_read, mem_write, imm_type, copy_reg;
  logic br_eq, br_neq, br_lt, br_gt, br_lte, br_gte, jump, illegal_op, mem_error;
  logic [1:0] shift_control;
  logic [3:0] alu_select;
  logic [15:0] retired_count;
  logic v2 = 1'b0, f2 = 1'b0;
  logic [3:0] op2 = '0;
  logic rdy2, cv2, mr2, mw2, imm2, cp2, beq2, bne2, blt2, bgt2, ble2, bge2, j2, ill2, err2;
  logic [1:0] sh2;
  logic [3:0] alu2;
  logic [1:0] cnt2;
  int n_cmp = 0;
  int n_err = 0;
  int held;
  always #5 clock = ~clock;
  ctrl_sequencer dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .func1(func1), .mem_ready(mem_ready), .flush(flush),
    .ctrl_valid(ctrl_valid), .shift_control(shift_control), .mem_read(mem_read),
    .mem_write(mem_write), .imm_type(imm_type), .alu_select(alu_select), .copy_reg(copy_reg),
    .br_eq(br_eq), .br_neq(br_neq), .br_lt(br_lt), .br_gt(br_gt), .br_lte(br_lte),
    .br_gte(br_gte), .jump(jump), .illegal_op(illegal_op), .mem_error(mem_error),
    .retired_count(retired_count)
  );
  ctrl_sequencer #(.COUNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .instr_valid(v2), .instr_ready(rdy2),
    .opcode(op2), .func1(f2), .mem_ready(1'b0), .flush(1'b0),
    .ctrl_valid(cv2), .shift_control(sh2), .mem_read(mr2),
    .mem_write(mw2), .imm_type(imm2), .alu_select(alu2), .copy_reg(cp2),
    .br_eq(beq2), .br_neq(bne2), .br_lt(blt2), .br_gt(bgt2), .br_lte(ble2),
    .br_gte(bge2), .jump(j2), .illegal_op(ill2), .mem_error(err2),
    .retired_count(cnt2)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  initial begin
    tick();
    tick();
    reset = 1'b0;
    check("rst_valid", ctrl_valid, 0);
    check("rst_ready", instr_ready, 1);
    check("rst_count", retired_count, 0);
    check("rst_alu", alu_select, 0);
    // alu op, single cycle
    instr_valid = 1; opcode = 4'h3; func1 = 1;
    tick();
    instr_valid = 0;
    check("alu_valid", ctrl_valid, 1);
    check("alu_sel", alu_select, 3);
    check("alu_count", retired_count, 1);
    tick();
    check("alu_drop", ctrl_valid, 0);
    check("alu_zero", alu_select, 0);
    // mem read completes on 4th wait cycle
    instr_valid = 1; opcode = 4'h1; func1 = 0;
    tick();
    instr_valid = 0;
    for (int i = 1; i <= 4; i++) begin
      check("rd_held", {ctrl_valid, mem_read, mem_write, instr_ready}, 4'b1100);
      if (i == 4) mem_ready = 1;
      tick();
    end
    mem_ready = 0;
    check("rd_done", {ctrl_valid, mem_read, instr_ready}, 3'b001);
    check("rd_count", retired_count, 2);
    // mem write times out
    instr_valid = 1; opcode = 4'h2; func1 = 1;
    tick();
    instr_valid = 0;
    held = 0;
    for (int i = 1; i <= 16; i++) begin
      if (ctrl_valid && mem_write && imm_type && !mem_error && !instr_ready) held++;
      tick();
    end
    check("wr_held", held, 16);
    check("wr_error", mem_error, 1);
    check("wr_drop", {ctrl_valid, mem_write, imm_type}, 0);
    check("wr_count", retired_count, 2);
    tick();
    check("wr_pulse", mem_error, 0);
    check("wr_ready", instr_ready, 1);
    // jump then shift held valid
    instr_valid = 1; opcode = 4'hD; func1 = 0;
    tick();
    opcode = 4'h5;
    check("jmp_out", {ctrl_valid, jump, imm_type, instr_ready}, 4'b1100);
    check("jmp_count", retired_count, 3);
    tick();
    check("bub1", {ctrl_valid, jump, instr_ready}, 0);
    tick();
    check("bub2", {ctrl_valid, jump, instr_ready}, 3'b001);
    tick();
    instr_valid = 0;
    check("shl", {ctrl_valid, shift_control}, 3'b101);
    check("shl_count", retired_count, 4);
    tick();
    // flush during MEM_WAIT with branch offered
    instr_valid = 1; opcode = 4'h1; func1 = 1;
    tick();
    opcode = 4'h9; func1 = 0;
    check("fl_wait", {ctrl_valid, mem_write}, 2'b11);
    tick();
    flush = 1;
    tick();
    flush = 0; instr_valid = 0;
    check("fl_out", {ctrl_valid, mem_write, br_eq, mem_error}, 0);
    check("fl_ready", instr_ready, 1);
    check("fl_count", retired_count, 4);
    tick();
    check("fl_noacc", {ctrl_valid, br_eq, mem_error}, 0);
    instr_valid = 1; flush = 1;
    tick();
    flush = 0; instr_valid = 0;
    check("fl_idle", {ctrl_valid, br_eq}, 0);
    // back-to-back branches
    instr_valid = 1; opcode = 4'h9; func1 = 0;
    tick();
    opcode = 4'hB; func1 = 1;
    check("beq", {ctrl_valid, br_eq, br_neq}, 3'b110);
    tick();
    instr_valid = 0;
    check("blte", {ctrl_valid, br_lte, br_gte, br_eq}, 4'b1100);
    check("br_count", retired_count, 6);
    tick();
    // mem_ready coincides with timeout: completion wins
    instr_valid = 1; opcode = 4'h1; func1 = 0;
    tick();
    instr_valid = 0;
    for (int i = 1; i <= 16; i++) begin
      if (i == 16) mem_ready = 1;
      tick();
    end
    mem_ready = 0;
    check("tie_err", mem_error, 0);
    check("tie_count", retired_count, 7);
    // illegal op and counter wrap on the narrow instance
    v2 = 1; op2 = 4'hF;
    tick();
    v2 = 0;
    check("ill_pulse", ill2, 1);
    check("ill_valid", cv2, 0);
    check("ill_count", cnt2, 0);
    tick();
    check("ill_end", ill2, 0);
    v2 = 1; op2 = 4'h0;
    for (int i = 0; i < 5; i++) tick();
    v2 = 0;
    check("wrap", cnt2, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
